// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetches one instruction per cycle from instruction memory
// into a small circular buffer that feeds decode, with branch-redirect flushing.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [4:0]  fill_count
);

  localparam int                PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      insn_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [31:0]      fetch_pc;
  logic             full;
  logic             push;
  logic             pop;

  // A pop frees a slot in the same cycle, so a full queue can still fetch while decode drains it.
  always_comb begin
    full      = (count == FULL_COUNT);
    valid_out = (count != '0);
    pop       = valid_out & ~stall & ~redirect;
    push      = ~redirect & (~full | pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Storage is never observed while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      insn_mem[wr_ptr] <= imem_rdata;
    end
  end

  always_comb begin
    imem_addr  = fetch_pc;
    fill_count = 5'(count);
    instr_out  = valid_out ? insn_mem[rd_ptr] : NOP_INSN;
    pc_out     = valid_out ? pc_mem[rd_ptr]   : 32'h0000_0000;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  logic        clk;
  logic        rstn;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        valid_out;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [4:0]  fill_count;

  int vectors;
  int miscompares;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_INSN(NOP_INSN)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .stall      (stall),
    .valid_out  (valid_out),
    .instr_out  (instr_out),
    .pc_out     (pc_out),
    .fill_count (fill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: the word at an address encodes that address.
  assign imem_rdata = 32'h1000_0000 | imem_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {pc, insn} pairs and the next fetch address.
  logic [63:0] mq[$];
  logic [31:0] m_pc = RESET_PC;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq.delete();
      m_pc = RESET_PC;
    end else if (redirect) begin
      mq.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (mq.size() != 0 && !stall) void'(mq.pop_front());
      if (mq.size() < DEPTH) begin
        mq.push_back({m_pc, 32'h1000_0000 | m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    check("model_valid", {31'b0, valid_out}, {31'b0, (mq.size() != 0)});
    check("model_fill",  {27'b0, fill_count}, 32'(mq.size()));
    check("model_addr",  imem_addr, m_pc);
    check("model_pc",    pc_out,    (mq.size() != 0) ? mq[0][63:32] : 32'h0);
    check("model_instr", instr_out, (mq.size() != 0) ? mq[0][31:0]  : NOP_INSN);
  end

  task automatic apply_stimulus(input logic r, input logic [31:0] rpc, input logic s);
    redirect    = r;
    redirect_pc = rpc;
    stall       = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic v, input logic [31:0] pc,
                              input logic [4:0] fill, input logic [31:0] addr);
    check({name, "_valid"}, {31'b0, valid_out}, {31'b0, v});
    check({name, "_pc"},    pc_out,    v ? pc : 32'h0);
    check({name, "_instr"}, instr_out, v ? (32'h1000_0000 | pc) : NOP_INSN);
    check({name, "_fill"},  {27'b0, fill_count}, {27'b0, fill});
    check({name, "_addr"},  imem_addr, addr);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstn        = 1'b0;
    apply_stimulus(1'b0, 32'h0, 1'b0);
    tick();
    tick();
    check_output("reset", 1'b0, 32'h0, 5'd0, RESET_PC);

    // Free-running fetch from reset: one entry in flight, pc advancing by 4.
    rstn = 1'b1;
    tick();
    check_output("run_e1", 1'b1, 32'h0, 5'd1, 32'h4);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_output("run", 1'b1, 32'(4 * k), 5'd1, 32'(4 * k + 4));
    end

    // Stall from reset fills the queue, then drains with no bubble.
    rstn = 1'b0;
    #1;
    check_output("reset2", 1'b0, 32'h0, 5'd0, RESET_PC);
    apply_stimulus(1'b0, 32'h0, 1'b1);
    rstn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_output("stall_fill", 1'b1, 32'h0, 5'((i < 4) ? i : 4), 32'(4 * ((i < 4) ? i : 4)));
    end
    apply_stimulus(1'b0, 32'h0, 1'b0);
    check_output("drain0", 1'b1, 32'h0, 5'd4, 32'h10);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_output("drain", 1'b1, 32'(4 * k), 5'd4, 32'(16 + 4 * k));
    end

    // Redirect from a full queue, unaligned target.
    apply_stimulus(1'b1, 32'h0000_0203, 1'b0);
    tick();
    check_output("redir", 1'b0, 32'h0, 5'd0, 32'h0000_0200);
    apply_stimulus(1'b0, 32'h0, 1'b0);
    tick();
    check_output("redir_tgt", 1'b1, 32'h0000_0200, 5'd1, 32'h0000_0204);

    // Redirect coinciding with stall still flushes.
    apply_stimulus(1'b0, 32'h0, 1'b1);
    tick();
    tick();
    tick();
    check_output("refill", 1'b1, 32'h0000_0200, 5'd4, 32'h0000_0210);
    apply_stimulus(1'b1, 32'h0000_0103, 1'b1);
    tick();
    check_output("redir_stall", 1'b0, 32'h0, 5'd0, 32'h0000_0100);
    apply_stimulus(1'b0, 32'h0, 1'b0);
    tick();
    check_output("redir_stall_tgt", 1'b1, 32'h0000_0100, 5'd1, 32'h0000_0104);

    // Fetch address wraps through the top of the address space.
    apply_stimulus(1'b1, 32'hFFFF_FFF8, 1'b0);
    tick();
    check_output("wrap_redir", 1'b0, 32'h0, 5'd0, 32'hFFFF_FFF8);
    apply_stimulus(1'b0, 32'h0, 1'b0);
    tick();
    check_output("wrap0", 1'b1, 32'hFFFF_FFF8, 5'd1, 32'hFFFF_FFFC);
    tick();
    check_output("wrap1", 1'b1, 32'hFFFF_FFFC, 5'd1, 32'h0000_0000);
    tick();
    check_output("wrap2", 1'b1, 32'h0000_0000, 5'd1, 32'h0000_0004);

    // Asynchronous reset pulse between edges with three entries queued.
    apply_stimulus(1'b1, 32'h0000_0040, 1'b1);
    tick();
    apply_stimulus(1'b0, 32'h0, 1'b1);
    tick();
    tick();
    tick();
    check_output("pre_areset", 1'b1, 32'h0000_0040, 5'd3, 32'h0000_004C);
    #2;
    rstn = 1'b0;
    #1;
    check_output("areset", 1'b0, 32'h0, 5'd0, RESET_PC);
    rstn = 1'b1;
    apply_stimulus(1'b0, 32'h0, 1'b0);
    tick();
    check_output("post_areset", 1'b1, RESET_PC, 5'd1, RESET_PC + 32'd4);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
